// File: rtl/rv_issue_queue_if.sv
// Bundle of allocate, wakeup, issue and status signals for rv_issue_queue.
// master drives requests and observes status; slave is the queue itself.
interface rv_issue_queue_if #(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g   = 7,
  parameter int q_tag_width_g   = 6
);
  logic                                   in_vld;
  logic [0:q_dat_width_g-1]               in_dat;
  logic [0:q_tag_width_g-1]               in_tag;
  logic                                   in_rdy;
  logic                                   wk_vld;
  logic [0:q_tag_width_g-1]               wk_tag;
  logic                                   hold;
  logic [0:q_num_entries_g-1]             q_cond;
  logic [0:q_dat_width_g*q_num_entries_g-1] q_din;
  logic                                   iss_vld;
  logic [0:4]                             q_cnt;
  logic                                   q_full;
  logic                                   q_ovf;

  modport master (
    output in_vld, in_dat, in_tag, in_rdy, wk_vld, wk_tag, hold,
    input  q_cond, q_din, iss_vld, q_cnt, q_full, q_ovf
  );

  modport slave (
    input  in_vld, in_dat, in_tag, in_rdy, wk_vld, wk_tag, hold,
    output q_cond, q_din, iss_vld, q_cnt, q_full, q_ovf
  );
endinterface

// File: rtl/rv_issue_queue.sv
// Collapsing issue queue: oldest entry at the top index, oldest-ready-first issue,
// tag wakeup with same-cycle bypass for newly allocated entries.
module rv_issue_queue #(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g   = 7,
  parameter int q_tag_width_g   = 6
) (
  input  logic              clk,
  input  logic              rst,
  rv_issue_queue_if.slave   bus
);
  localparam int N = q_num_entries_g;
  localparam int W = q_dat_width_g;
  localparam int T = q_tag_width_g;

  logic [N-1:0] valid_reg, valid_next;
  logic [N-1:0] ready_reg, ready_next;
  logic [0:T-1] tag_reg [N];
  logic [0:T-1] tag_next [N];
  logic [0:W-1] dat_reg [N];
  logic [0:W-1] dat_next [N];
  logic [4:0]   cnt_reg, cnt_next;
  logic         ovf_reg, ovf_next;

  logic [N-1:0] cond;
  logic         iss;
  logic         full;
  logic         accept;
  int           sel;
  int           wr_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign cond[gi]                 = valid_reg[gi] & ready_reg[gi] & ~bus.hold;
      assign bus.q_cond[gi]           = cond[gi];
      assign bus.q_din[gi*W +: W]     = dat_reg[gi];
    end
  endgenerate

  assign iss         = |cond;
  assign full        = (cnt_reg == 5'(N));
  assign bus.iss_vld = iss;
  assign bus.q_cnt   = cnt_reg;
  assign bus.q_full  = full;
  assign bus.q_ovf   = ovf_reg;

  always_comb begin
    sel = 0;
    for (int i = 0; i < N; i++) begin
      if (cond[i]) sel = i;
    end

    valid_next = valid_reg;
    ready_next = ready_reg;
    tag_next   = tag_reg;
    dat_next   = dat_reg;

    // Collapse: everything younger than the issued entry moves up one slot.
    for (int j = 1; j < N; j++) begin
      if (iss && j <= sel) begin
        valid_next[j] = valid_reg[j-1];
        ready_next[j] = ready_reg[j-1];
        tag_next[j]   = tag_reg[j-1];
        dat_next[j]   = dat_reg[j-1];
      end
    end
    if (iss) begin
      valid_next[0] = 1'b0;
      ready_next[0] = 1'b0;
      tag_next[0]   = '0;
      dat_next[0]   = '0;
    end

    if (bus.wk_vld) begin
      for (int j = 0; j < N; j++) begin
        if (valid_next[j] && tag_next[j] == bus.wk_tag) ready_next[j] = 1'b1;
      end
    end

    accept = bus.in_vld && !full;
    wr_idx = N - 1 - int'(cnt_reg) + int'(iss);
    for (int j = 0; j < N; j++) begin
      if (accept && j == wr_idx) begin
        valid_next[j] = 1'b1;
        ready_next[j] = bus.in_rdy || (bus.wk_vld && bus.wk_tag == bus.in_tag);
        tag_next[j]   = bus.in_tag;
        dat_next[j]   = bus.in_dat;
      end
    end

    cnt_next = cnt_reg + 5'(accept) - 5'(iss);
    ovf_next = bus.in_vld && full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      ready_reg <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        tag_reg[i] <= '0;
        dat_reg[i] <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      ready_reg <= ready_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      for (int i = 0; i < N; i++) begin
        tag_reg[i] <= tag_next[i];
        dat_reg[i] <= dat_next[i];
      end
    end
  end
endmodule

// File: tb/tb_rv_issue_queue.sv
// Scenario bench for rv_issue_queue: expected issue payloads are queued when
// stimulus is driven and checked by a monitor as the queue issues them.
module tb_rv_issue_queue;
  localparam int N = 16;
  localparam int W = 7;
  localparam int T = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [0:W-1] exp_q[$];

  rv_issue_queue_if #(.q_num_entries_g(N), .q_dat_width_g(W), .q_tag_width_g(T)) bus ();

  rv_issue_queue #(.q_num_entries_g(N), .q_dat_width_g(W), .q_tag_width_g(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:W-1] slot(input int i);
    return bus.q_din[i*W +: W];
  endfunction

  // Issue monitor: sampled mid-cycle, compares the issued payload with the scoreboard head.
  always @(negedge clk) begin : mon
    int hi;
    logic [0:W-1] got;
    logic [0:W-1] want;
    if (!rst && bus.iss_vld) begin
      hi = 0;
      for (int i = 0; i < N; i++) if (bus.q_cond[i]) hi = i;
      got = bus.q_din[hi*W +: W];
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue: payload %h from index %0d, nothing expected", got, hi);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL issue: payload %h from index %0d, want %h", got, hi, want);
        else begin
          n_pass++;
          $display("issue idx=%0d payload=%h", hi, got);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_vld = 0; bus.in_dat = '0; bus.in_tag = '0; bus.in_rdy = 0;
    bus.wk_vld = 0; bus.wk_tag = '0; bus.hold = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    cycle();
  endtask

  task automatic alloc(input logic [0:W-1] d, input logic [0:T-1] t, input logic r);
    bus.in_vld = 1; bus.in_dat = d; bus.in_tag = t; bus.in_rdy = r;
    cycle();
    bus.in_vld = 0; bus.in_rdy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_vld = 0; bus.in_dat = '0; bus.in_tag = '0; bus.in_rdy = 0;
    bus.wk_vld = 0; bus.wk_tag = '0; bus.hold = 0;
    #2;
    n_checks++; if (bus.q_cnt !== 5'd0) $display("FAIL reset_cnt: got %0d want 0", bus.q_cnt); else n_pass++;
    n_checks++; if (bus.q_cond !== '0) $display("FAIL reset_cond: got %h want 0", bus.q_cond); else n_pass++;
    n_checks++; if (bus.iss_vld !== 1'b0) $display("FAIL reset_iss: got %b want 0", bus.iss_vld); else n_pass++;
    n_checks++; if (bus.q_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.q_full); else n_pass++;
    n_checks++; if (bus.q_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.q_ovf); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_in_order();
    apply_reset();
    bus.hold = 1;
    for (int k = 0; k < 3; k++) alloc(7'(17 * (k + 1)), 6'h00, 1'b1);
    #1;
    n_checks++; if (bus.q_cnt !== 5'd3) $display("FAIL order_cnt: got %0d want 3", bus.q_cnt); else n_pass++;
    n_checks++; if (bus.q_cond !== '0) $display("FAIL order_hold_cond: got %h want 0", bus.q_cond); else n_pass++;
    n_checks++; if (slot(15) !== 7'h11) $display("FAIL order_slot15: got %h want 11", slot(15)); else n_pass++;
    n_checks++; if (slot(14) !== 7'h22) $display("FAIL order_slot14: got %h want 22", slot(14)); else n_pass++;
    n_checks++; if (slot(13) !== 7'h33) $display("FAIL order_slot13: got %h want 33", slot(13)); else n_pass++;
    exp_q.push_back(7'h11); exp_q.push_back(7'h22); exp_q.push_back(7'h33);
    bus.hold = 0;
    repeat (3) cycle();
    n_checks++; if (bus.q_cnt !== 5'd0) $display("FAIL order_drain_cnt: got %0d want 0", bus.q_cnt); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL order_pending: got %0d want 0", exp_q.size()); else n_pass++;
    $display("test_in_order done");
  endtask

  task automatic test_wakeup();
    logic [0:N-1] exp_cond;
    apply_reset();
    bus.hold = 1;
    alloc(7'h15, 6'h05, 1'b0);
    alloc(7'h26, 6'h03, 1'b1);
    bus.hold = 0; #1;
    exp_cond = '0; exp_cond[14] = 1'b1;
    n_checks++; if (bus.q_cond !== exp_cond) $display("FAIL wake_before: got %h want %h", bus.q_cond, exp_cond); else n_pass++;
    bus.hold = 1;
    bus.wk_vld = 1; bus.wk_tag = 6'h05;
    cycle();
    bus.wk_vld = 0; bus.hold = 0;
    exp_q.push_back(7'h15); exp_q.push_back(7'h26);
    #1;
    exp_cond = '0; exp_cond[14] = 1'b1; exp_cond[15] = 1'b1;
    n_checks++; if (bus.q_cond !== exp_cond) $display("FAIL wake_after: got %h want %h", bus.q_cond, exp_cond); else n_pass++;
    cycle();
    exp_cond = '0; exp_cond[15] = 1'b1;
    n_checks++; if (bus.q_cond !== exp_cond) $display("FAIL wake_shift: got %h want %h", bus.q_cond, exp_cond); else n_pass++;
    cycle();
    n_checks++; if (bus.q_cnt !== 5'd0) $display("FAIL wake_cnt: got %0d want 0", bus.q_cnt); else n_pass++;
    $display("test_wakeup done");
  endtask

  task automatic test_middle_issue();
    apply_reset();
    bus.hold = 1;
    alloc(7'h0A, 6'h01, 1'b0);
    alloc(7'h0B, 6'h02, 1'b1);
    alloc(7'h0C, 6'h03, 1'b0);
    exp_q.push_back(7'h0B);
    bus.hold = 0;
    cycle();
    #1;
    n_checks++; if (bus.q_cnt !== 5'd2) $display("FAIL mid_cnt: got %0d want 2", bus.q_cnt); else n_pass++;
    n_checks++; if (slot(14) !== 7'h0C) $display("FAIL mid_slot14: got %h want 0c", slot(14)); else n_pass++;
    n_checks++; if (slot(15) !== 7'h0A) $display("FAIL mid_slot15: got %h want 0a", slot(15)); else n_pass++;
    n_checks++; if (bus.iss_vld !== 1'b0) $display("FAIL mid_iss: got %b want 0", bus.iss_vld); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL mid_pending: got %0d want 0", exp_q.size()); else n_pass++;
    $display("test_middle_issue done");
  endtask

  task automatic test_full_ovf();
    apply_reset();
    bus.hold = 1;
    for (int k = 0; k < N; k++) alloc(7'(k + 1), 6'h00, 1'b1);
    #1;
    n_checks++; if (bus.q_full !== 1'b1) $display("FAIL full_flag: got %b want 1", bus.q_full); else n_pass++;
    n_checks++; if (bus.q_cnt !== 5'd16) $display("FAIL full_cnt: got %0d want 16", bus.q_cnt); else n_pass++;
    n_checks++; if (bus.q_ovf !== 1'b0) $display("FAIL full_ovf_early: got %b want 0", bus.q_ovf); else n_pass++;
    alloc(7'h7F, 6'h00, 1'b1);
    #1;
    n_checks++; if (bus.q_ovf !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", bus.q_ovf); else n_pass++;
    n_checks++; if (bus.q_cnt !== 5'd16) $display("FAIL ovf_cnt: got %0d want 16", bus.q_cnt); else n_pass++;
    n_checks++; if (slot(0) !== 7'h10) $display("FAIL ovf_slot0: got %h want 10", slot(0)); else n_pass++;
    n_checks++; if (slot(15) !== 7'h01) $display("FAIL ovf_slot15: got %h want 01", slot(15)); else n_pass++;
    cycle();
    n_checks++; if (bus.q_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.q_ovf); else n_pass++;
    exp_q.push_back(7'h01);
    bus.hold = 0;
    cycle();
    #1;
    n_checks++; if (bus.q_cnt !== 5'd15) $display("FAIL free_cnt: got %0d want 15", bus.q_cnt); else n_pass++;
    n_checks++; if (bus.q_full !== 1'b0) $display("FAIL free_full: got %b want 0", bus.q_full); else n_pass++;
    bus.hold = 1;
    alloc(7'h55, 6'h00, 1'b1);
    #1;
    n_checks++; if (slot(0) !== 7'h55) $display("FAIL refill_slot0: got %h want 55", slot(0)); else n_pass++;
    n_checks++; if (bus.q_full !== 1'b1) $display("FAIL refill_full: got %b want 1", bus.q_full); else n_pass++;
    // Full with an issue in the same cycle: the allocate is still dropped.
    for (int k = 2; k <= N; k++) exp_q.push_back(7'(k));
    exp_q.push_back(7'h55);
    bus.hold = 0;
    alloc(7'h66, 6'h00, 1'b1);
    #1;
    n_checks++; if (bus.q_ovf !== 1'b1) $display("FAIL ovf_with_issue: got %b want 1", bus.q_ovf); else n_pass++;
    n_checks++; if (bus.q_cnt !== 5'd15) $display("FAIL ovf_issue_cnt: got %0d want 15", bus.q_cnt); else n_pass++;
    repeat (15) cycle();
    n_checks++; if (bus.q_cnt !== 5'd0) $display("FAIL full_drain_cnt: got %0d want 0", bus.q_cnt); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL full_pending: got %0d want 0", exp_q.size()); else n_pass++;
    $display("test_full_ovf done");
  endtask

  task automatic test_bypass();
    logic [0:N-1] exp_cond;
    apply_reset();
    bus.hold = 1;
    alloc(7'h31, 6'h01, 1'b0);
    alloc(7'h32, 6'h02, 1'b1);
    alloc(7'h33, 6'h03, 1'b0);
    alloc(7'h34, 6'h04, 1'b0);
    bus.hold = 0;
    bus.in_vld = 1; bus.in_dat = 7'h39; bus.in_tag = 6'h09; bus.in_rdy = 0;
    bus.wk_vld = 1; bus.wk_tag = 6'h09;
    exp_q.push_back(7'h32);
    cycle();
    bus.in_vld = 0; bus.wk_vld = 0;
    #1;
    exp_cond = '0; exp_cond[12] = 1'b1;
    n_checks++; if (bus.q_cnt !== 5'd4) $display("FAIL byp_cnt: got %0d want 4", bus.q_cnt); else n_pass++;
    n_checks++; if (slot(12) !== 7'h39) $display("FAIL byp_slot12: got %h want 39", slot(12)); else n_pass++;
    n_checks++; if (slot(13) !== 7'h34) $display("FAIL byp_slot13: got %h want 34", slot(13)); else n_pass++;
    n_checks++; if (bus.q_cond !== exp_cond) $display("FAIL byp_cond: got %h want %h", bus.q_cond, exp_cond); else n_pass++;
    exp_q.push_back(7'h39);
    cycle();
    n_checks++; if (bus.q_cnt !== 5'd3) $display("FAIL byp_after_cnt: got %0d want 3", bus.q_cnt); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL byp_pending: got %0d want 0", exp_q.size()); else n_pass++;
    $display("test_bypass done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.hold = 1;
    for (int k = 0; k < 5; k++) alloc(7'(8'h40 + k), 6'h00, 1'b1);
    #1;
    n_checks++; if (bus.q_cnt !== 5'd5) $display("FAIL arst_pre_cnt: got %0d want 5", bus.q_cnt); else n_pass++;
    bus.hold = 0;
    #1;
    n_checks++; if (bus.iss_vld !== 1'b1) $display("FAIL arst_pre_iss: got %b want 1", bus.iss_vld); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.q_cnt !== 5'd0) $display("FAIL arst_cnt: got %0d want 0", bus.q_cnt); else n_pass++;
    n_checks++; if (bus.q_cond !== '0) $display("FAIL arst_cond: got %h want 0", bus.q_cond); else n_pass++;
    n_checks++; if (bus.iss_vld !== 1'b0) $display("FAIL arst_iss: got %b want 0", bus.iss_vld); else n_pass++;
    bus.hold = 1;
    bus.in_vld = 1; bus.in_dat = 7'h44; bus.in_tag = 6'h00; bus.in_rdy = 1;
    #3 rst = 1'b0;
    cycle();
    bus.in_vld = 0;
    #1;
    n_checks++; if (bus.q_cnt !== 5'd1) $display("FAIL arst_first_cnt: got %0d want 1", bus.q_cnt); else n_pass++;
    n_checks++; if (slot(15) !== 7'h44) $display("FAIL arst_first_slot: got %h want 44", slot(15)); else n_pass++;
    $display("test_async_reset done");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    test_reset();
    test_in_order();
    test_wakeup();
    test_middle_issue();
    test_full_ovf();
    test_bypass();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv_issue_queue.md
RV_ISSUE_QUEUE -- requirements
Module: rv_issue_queue

Interface
REQ-001 SHALL have parameter q_num_entries_g, default 16, number of entries; legal values are 8, 12 and 16.
REQ-002 SHALL have parameter q_dat_width_g, default 7, width of the payload per entry.
REQ-003 SHALL have parameter q_tag_width_g, default 6, width of the source tag per entry.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_vld, input, 1 bit: allocate request.
REQ-007 SHALL have port in_dat, input, [0:q_dat_width_g-1]: payload for the new entry.
REQ-008 SHALL have port in_tag, input, [0:q_tag_width_g-1]: source tag the new entry awaits.
REQ-009 SHALL have port in_rdy, input, 1 bit: the new entry's source is already available.
REQ-010 SHALL have port wk_vld, input, 1 bit: wakeup broadcast valid.
REQ-011 SHALL have port wk_tag, input, [0:q_tag_width_g-1]: wakeup tag.
REQ-012 SHALL have port hold, input, 1 bit: downstream cannot accept an issue this cycle.
REQ-013 SHALL have port q_cond, output, [0:q_num_entries_g-1]: per-entry valid & ready & ~hold; drives the downstream priority mux select.
REQ-014 SHALL have port q_din, output, [0:q_dat_width_g*q_num_entries_g-1]: entry i payload at bits i*q_dat_width_g through i*q_dat_width_g+q_dat_width_g-1.
REQ-015 SHALL have port iss_vld, output, 1 bit: OR of q_cond.
REQ-016 SHALL have port q_cnt, output, [0:4]: number of valid entries.
REQ-017 SHALL have port q_full, output, 1 bit: q_cnt equals q_num_entries_g.
REQ-018 SHALL have port q_ovf, output, 1 bit: one-cycle registered pulse reporting a dropped allocate.

Function
REQ-019 SHALL store per entry: valid, ready, tag and payload; entry q_num_entries_g-1 is the oldest.
REQ-020 SHALL keep valid entries contiguous in indices q_num_entries_g-q_cnt through q_num_entries_g-1 at all times.
REQ-021 SHALL select issue index s as the highest index with q_cond set, which matches the downstream mux priority; q_cond, iss_vld and q_din are combinational from state and hold.
REQ-022 SHALL, on an edge where iss_vld=1, remove entry s and shift entries 0..s-1 up by one index, carrying all fields.
REQ-023 SHALL accept an allocate when in_vld=1 and q_full=0, writing index q_num_entries_g-q_cnt-1+iss_vld, evaluated after the shift of REQ-022.
REQ-024 SHALL drop an allocate when in_vld=1 and q_full=0 is false, even if an issue occurs the same cycle, and SHALL assert q_ovf in the following cycle.
REQ-025 SHALL set ready on the new entry if in_rdy=1, or if wk_vld=1 and wk_tag equals in_tag in the same cycle (bypass).
REQ-026 SHALL, when wk_vld=1, set ready at the next edge for every valid entry whose tag equals wk_tag, applied after the shift.
REQ-027 SHALL make ready entries visible on q_cond the cycle after the write or wakeup edge; minimum allocate-to-issue latency is 1 cycle.
REQ-028 SHALL update q_cnt by +accept -iss_vld per edge; a simultaneous accept and issue leaves q_cnt unchanged.
REQ-029 SHALL, for entries whose valid=0, drive ready=0 and contribute 0 to q_cond; their payload is don't-care.

Reset
REQ-030 SHALL, while rst=1 and independent of clk, clear all valid, ready, tag and payload bits to 0 and drive q_cond=0, iss_vld=0, q_cnt=0, q_full=0 and q_ovf=0.
REQ-031 SHALL discard in-flight allocates, wakeups and issues when rst asserts mid-operation, and SHALL accept an allocate on the first edge after rst deasserts.

Verification (N=16, W=7, tag=6)
REQ-032 SHALL be covered by this scenario: reset; hold=1; allocate payloads 0x11, 0x22, 0x33 with in_rdy=1 on consecutive cycles -> entries land at 15, 14, 13; q_cnt=3; q_cond=0. Then release hold -> iss_vld for 3 cycles, removing 0x11, 0x22, 0x33 in order; q_cnt=0.
REQ-033 SHALL be covered by this scenario: entry 15 with tag 0x05 not ready, entry 14 ready; wk_vld=1, wk_tag=0x05 -> the next cycle q_cond[14:15]=11; entry 15 issues first, then entry 14.
REQ-034 SHALL be covered by this scenario: entries 15 (not ready), 14 (ready) and 13 (not ready) -> 14 issues; 13's payload moves to 14; q_cnt goes from 3 to 2; entry 15 is unchanged.
REQ-035 SHALL be covered by this scenario: hold=1 and 16 allocates -> q_full=1. A 17th in_vld -> dropped; q_ovf=1 for exactly one cycle; q_cnt=16. Then release hold -> the first issue frees slot 0.
REQ-036 SHALL be covered by this scenario: q_cnt=4, with issue of index 14, an allocate with in_tag=0x09, and wk_vld=1 with wk_tag=0x09 in the same cycle -> the new entry lands at 12 and is ready; q_cnt=4.
REQ-037 SHALL be covered by this scenario: rst pulse between clock edges with q_cnt=5 -> q_cnt, q_cond and iss_vld go to 0 immediately, without waiting for a clock edge.
